// File: rtl/de3d_tc_addr_gen.sv
// Texture-cache address generator: four bilinear corner addresses, border flags
// and bank-sorted tag read addresses, as a 2-stage valid/ready pipeline.

module de3d_tc_axis #(
  parameter int UV_W   = 11,
  parameter int ADDR_W = 9
) (
  input  logic [UV_W-1:0]   c,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] m,
  output logic [ADDR_W-1:0] a,
  output logic              brd
);
  logic              neg, gt;
  logic [ADDR_W:0]   t;

  assign neg = c[UV_W-1];
  assign gt  = !neg && (c[UV_W-2:0] > (UV_W-1)'(m));
  // Mirror period is 2*(m+1); fold the upper half back onto 0..m.
  assign t   = c[ADDR_W:0] & {m, 1'b1};

  always_comb begin
    a   = c[ADDR_W-1:0] & m;
    brd = 1'b0;
    case (mode)
      2'b01: begin
        if (neg)     a = '0;
        else if (gt) a = m;
        else         a = c[ADDR_W-1:0];
      end
      2'b10: begin
        if (t > {1'b0, m}) a = ~t[ADDR_W-1:0] & m;
        else               a = t[ADDR_W-1:0];
      end
      2'b11:   brd = neg | gt;
      default: ;
    endcase
  end
endmodule

module de3d_tc_addr_gen #(
  parameter int UV_W   = 11,
  parameter int ADDR_W = 9,
  parameter int TAG_W  = 5,
  parameter int MIP_W  = 4
) (
  input  logic              de_clk,
  input  logic              de_rst,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [UV_W-1:0]   ul_u,
  input  logic [UV_W-1:0]   ul_v,
  input  logic [1:0]        mode_x,
  input  logic [1:0]        mode_y,
  input  logic [ADDR_W-1:0] bitmask_x,
  input  logic [ADDR_W-1:0] bitmask_y,
  input  logic [2:0]        bpt,
  input  logic [4:0]        tfmt,
  input  logic              pal_mode,
  input  logic              clip,
  input  logic [MIP_W-1:0]  mipmap,
  input  logic              exact,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [ADDR_W-1:0] ul_x, ul_y, ur_x, ur_y, ll_x, ll_y, lr_x, lr_y,
  output logic              border_ul, border_ur, border_ll, border_lr,
  output logic              same_word,
  output logic [TAG_W-1:0]  ee_tag, eo_tag, oe_tag, oo_tag,
  output logic [4:0]        tfmt_o,
  output logic [2:0]        bpt_o,
  output logic              pal_mode_o,
  output logic              clip_o,
  output logic [MIP_W-1:0]  mipmap_o,
  output logic              exact_o
);
  localparam int STAGES = 2;
  localparam logic [UV_W-1:0] UV_MAX = {1'b0, {(UV_W-1){1'b1}}};

  logic [STAGES:1] vld_pipe;
  logic            s1_adv, s2_adv, push, s2_load;

  assign s2_adv  = !vld_pipe[2] || out_rdy;
  assign s1_adv  = !vld_pipe[1] || s2_adv;
  assign in_rdy  = s1_adv && !flush;
  assign push    = in_vld && in_rdy;
  assign s2_load = s2_adv && vld_pipe[1];
  assign out_vld = vld_pipe[2];

  always_ff @(posedge de_clk or posedge de_rst)
    if (de_rst)     vld_pipe <= '0;
    else if (flush) vld_pipe <= '0;
    else begin
      if (s1_adv) vld_pipe[1] <= push;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end

  // Clamp saturates the +1 neighbour instead of wrapping to negative.
  logic [UV_W-1:0] inc_u, inc_v;
  assign inc_u = (mode_x == 2'b01 && ul_u == UV_MAX) ? ul_u : ul_u + UV_W'(1);
  assign inc_v = (mode_y == 2'b01 && ul_v == UV_MAX) ? ul_v : ul_v + UV_W'(1);

  // Axis slots: 0=u, 1=inc_u, 2=v, 3=inc_v.
  logic [3:0][UV_W-1:0]   ax_c;
  logic [3:0][1:0]        ax_mode;
  logic [3:0][ADDR_W-1:0] ax_m, ax_a;
  logic [3:0]             ax_brd;

  assign ax_c    = {inc_v, ul_v, inc_u, ul_u};
  assign ax_mode = {mode_y, mode_y, mode_x, mode_x};
  assign ax_m    = {bitmask_y, bitmask_y, bitmask_x, bitmask_x};

  for (genvar g = 0; g < 4; g++) begin : g_axis
    de3d_tc_axis #(.UV_W(UV_W), .ADDR_W(ADDR_W)) u_axis (
      .c(ax_c[g]), .mode(ax_mode[g]), .m(ax_m[g]), .a(ax_a[g]), .brd(ax_brd[g])
    );
  end

  logic [3:0][ADDR_W-1:0] s1_a;
  logic [3:0]             s1_b;
  logic [2:0]             s1_bpt;
  logic [4:0]             s1_tfmt;
  logic                   s1_pal, s1_clip, s1_exact;
  logic [MIP_W-1:0]       s1_mip;

  always_ff @(posedge de_clk or posedge de_rst)
    if (de_rst) begin
      s1_a <= '0; s1_b <= '0; s1_bpt <= '0; s1_tfmt <= '0;
      s1_pal <= 1'b0; s1_clip <= 1'b0; s1_exact <= 1'b0; s1_mip <= '0;
    end else if (push) begin
      s1_a <= ax_a; s1_b <= ax_brd; s1_bpt <= bpt; s1_tfmt <= tfmt;
      s1_pal <= pal_mode; s1_clip <= clip; s1_exact <= exact; s1_mip <= mipmap;
    end

  // Word index per column (x of UL/LL and of UR/LR); corner tags in UL,UR,LL,LR order.
  logic [1:0][ADDR_W-1:0] xw;
  logic [3:0][TAG_W-1:0]  tag;
  logic [1:0]             sel;

  for (genvar g = 0; g < 2; g++) begin : g_col
    assign xw[g] = (s1_bpt == 3'b011) ? (s1_a[g] >> 3) :
                   (s1_bpt == 3'b100) ? (s1_a[g] >> 2) : (s1_a[g] >> 1);
  end
  for (genvar g = 0; g < 4; g++) begin : g_tag
    assign tag[g] = TAG_W'({s1_a[2 + g/2][2:1], xw[g%2][3:1]});
  end

  // Swapping columns/rows by parity is an XOR of the corner index with {q,p}.
  assign sel = {s1_a[2][0], xw[0][0]};

  always_ff @(posedge de_clk or posedge de_rst)
    if (de_rst) begin
      ul_x <= '0; ul_y <= '0; ur_x <= '0; ur_y <= '0;
      ll_x <= '0; ll_y <= '0; lr_x <= '0; lr_y <= '0;
      border_ul <= 1'b0; border_ur <= 1'b0; border_ll <= 1'b0; border_lr <= 1'b0;
      same_word <= 1'b0;
      ee_tag <= '0; eo_tag <= '0; oe_tag <= '0; oo_tag <= '0;
      tfmt_o <= '0; bpt_o <= '0; pal_mode_o <= 1'b0; clip_o <= 1'b0;
      mipmap_o <= '0; exact_o <= 1'b0;
    end else if (s2_load) begin
      ul_x <= s1_a[0]; ul_y <= s1_a[2]; ur_x <= s1_a[1]; ur_y <= s1_a[2];
      ll_x <= s1_a[0]; ll_y <= s1_a[3]; lr_x <= s1_a[1]; lr_y <= s1_a[3];
      border_ul <= s1_b[0] | s1_b[2];
      border_ur <= s1_b[1] | s1_b[2];
      border_ll <= s1_b[0] | s1_b[3];
      border_lr <= s1_b[1] | s1_b[3];
      same_word <= (xw[0] == xw[1]);
      ee_tag <= tag[sel];
      oe_tag <= tag[sel ^ 2'd1];
      eo_tag <= tag[sel ^ 2'd2];
      oo_tag <= tag[sel ^ 2'd3];
      tfmt_o <= s1_tfmt; bpt_o <= s1_bpt; pal_mode_o <= s1_pal; clip_o <= s1_clip;
      mipmap_o <= s1_mip; exact_o <= s1_exact;
    end
endmodule

// File: tb/tb_de3d_tc_addr_gen.sv
// Bench for de3d_tc_addr_gen: directed corner cases plus randomized traffic
// against an integer reference model and a latency-aware scoreboard.

module tb_de3d_tc_addr_gen;
  logic        de_clk = 1'b0;
  logic        de_rst, flush, in_vld, in_rdy, out_vld, out_rdy;
  logic [10:0] ul_u, ul_v;
  logic [1:0]  mode_x, mode_y;
  logic [8:0]  bitmask_x, bitmask_y;
  logic [2:0]  bpt, bpt_o;
  logic [4:0]  tfmt, tfmt_o;
  logic        pal_mode, clip, exact, pal_mode_o, clip_o, exact_o;
  logic [3:0]  mipmap, mipmap_o;
  logic [8:0]  ul_x, ul_y, ur_x, ur_y, ll_x, ll_y, lr_x, lr_y;
  logic        border_ul, border_ur, border_ll, border_lr, same_word;
  logic [4:0]  ee_tag, eo_tag, oe_tag, oo_tag;

  de3d_tc_addr_gen dut (
    .de_clk(de_clk), .de_rst(de_rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
    .ul_u(ul_u), .ul_v(ul_v), .mode_x(mode_x), .mode_y(mode_y),
    .bitmask_x(bitmask_x), .bitmask_y(bitmask_y), .bpt(bpt), .tfmt(tfmt),
    .pal_mode(pal_mode), .clip(clip), .mipmap(mipmap), .exact(exact),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .ul_x(ul_x), .ul_y(ul_y), .ur_x(ur_x), .ur_y(ur_y),
    .ll_x(ll_x), .ll_y(ll_y), .lr_x(lr_x), .lr_y(lr_y),
    .border_ul(border_ul), .border_ur(border_ur), .border_ll(border_ll), .border_lr(border_lr),
    .same_word(same_word),
    .ee_tag(ee_tag), .eo_tag(eo_tag), .oe_tag(oe_tag), .oo_tag(oo_tag),
    .tfmt_o(tfmt_o), .bpt_o(bpt_o), .pal_mode_o(pal_mode_o), .clip_o(clip_o),
    .mipmap_o(mipmap_o), .exact_o(exact_o)
  );

  always #5 de_clk = ~de_clk;

  typedef struct { logic [127:0] v; int acc; } ent_t;
  ent_t         sbq[$];
  int           n_vec = 0, n_err = 0, cyc = 0, n_pop = 0;
  bit           last_acc, stall_prev;
  logic [127:0] prev_obs;

  task automatic chk(input string tag, input logic [127:0] obs_v, input logic [127:0] exp_v);
    n_vec++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic chk_i(input string tag, input int obs_v, input int exp_v);
    chk(tag, 128'(obs_v), 128'(exp_v));
  endtask

  // ---- reference model: plain integer arithmetic on the addressing rules ----
  function automatic int sx(input logic [10:0] x);
    return x[10] ? int'(x) - 2048 : int'(x);
  endfunction

  function automatic int pmod(input int a, input int n);
    int r = a % n;
    return (r < 0) ? r + n : r;
  endfunction

  function automatic int inc(input int c, input int mode);
    int r;
    if (mode == 1 && c == 1023) return c;
    r = c + 1;
    return (r > 1023) ? r - 2048 : r;
  endfunction

  function automatic void res(input int c, input int mode, input int m, output int a, output bit b);
    int t;
    b = 1'b0;
    case (mode)
      1: a = (c < 0) ? 0 : (c > m) ? m : c;
      2: begin t = pmod(c, 2 * (m + 1)); a = (t <= m) ? t : 2 * m + 1 - t; end
      3: begin a = pmod(c, m + 1); b = (c < 0) || (c > m); end
      default: a = pmod(c, m + 1);
    endcase
  endfunction

  function automatic int widx(input int x);
    int bits = (bpt == 3'b011) ? 8 : (bpt == 3'b100) ? 16 : 32;
    return x / (32 / bits * 8 / 8 * 0 + 64 / bits);
  endfunction

  function automatic int tagof(input int x, input int y);
    return ((y / 2) % 4) * 8 + ((widx(x) / 2) % 8);
  endfunction

  function automatic logic [127:0] model();
    int ax[4], tg[4];
    bit b[4], p, q, same;
    int ee, eo, oe, oo;
    res(sx(ul_u), int'(mode_x), int'(bitmask_x), ax[0], b[0]);
    res(inc(sx(ul_u), int'(mode_x)), int'(mode_x), int'(bitmask_x), ax[1], b[1]);
    res(sx(ul_v), int'(mode_y), int'(bitmask_y), ax[2], b[2]);
    res(inc(sx(ul_v), int'(mode_y)), int'(mode_y), int'(bitmask_y), ax[3], b[3]);
    tg[0] = tagof(ax[0], ax[2]); tg[1] = tagof(ax[1], ax[2]);
    tg[2] = tagof(ax[0], ax[3]); tg[3] = tagof(ax[1], ax[3]);
    same = (widx(ax[0]) == widx(ax[1]));
    p = widx(ax[0]) % 2 == 1;
    q = ax[2] % 2 == 1;
    case ({p, q})
      2'b00:   begin ee = tg[0]; oe = tg[1]; eo = tg[2]; oo = tg[3]; end
      2'b10:   begin ee = tg[1]; oe = tg[0]; eo = tg[3]; oo = tg[2]; end
      2'b01:   begin ee = tg[2]; oe = tg[3]; eo = tg[0]; oo = tg[1]; end
      default: begin ee = tg[3]; oe = tg[2]; eo = tg[1]; oo = tg[0]; end
    endcase
    return {16'h0, 9'(ax[0]), 9'(ax[2]), 9'(ax[1]), 9'(ax[2]),
            9'(ax[0]), 9'(ax[3]), 9'(ax[1]), 9'(ax[3]),
            b[0] | b[2], b[1] | b[2], b[0] | b[3], b[1] | b[3], same,
            5'(ee), 5'(eo), 5'(oe), 5'(oo),
            tfmt, bpt, pal_mode, clip, mipmap, exact};
  endfunction

  function automatic logic [127:0] obs();
    return {16'h0, ul_x, ul_y, ur_x, ur_y, ll_x, ll_y, lr_x, lr_y,
            border_ul, border_ur, border_ll, border_lr, same_word,
            ee_tag, eo_tag, oe_tag, oo_tag,
            tfmt_o, bpt_o, pal_mode_o, clip_o, mipmap_o, exact_o};
  endfunction

  // One clock: check at negedge, then account for the edge. Pipeline holds at
  // most two items; the head is visible once two edges have passed since accept.
  task automatic tick();
    logic [127:0] e = '0;
    bit exp_vld, exp_rdy, acc;
    @(negedge de_clk);
    if (stall_prev) chk("stall_hold", obs(), prev_obs);
    exp_vld = sbq.size() > 0 && (cyc - sbq[0].acc >= 2);
    exp_rdy = !flush && (sbq.size() < 2 || out_rdy);
    chk("out_vld", 128'(out_vld), 128'(exp_vld));
    chk("in_rdy", 128'(in_rdy), 128'(exp_rdy));
    if (exp_vld && out_rdy) begin
      chk("out_data", obs(), sbq[0].v);
      sbq.delete(0);
      n_pop++;
    end
    acc = in_vld && exp_rdy;
    if (acc) e = model();
    stall_prev = exp_vld && !out_rdy && !flush;
    prev_obs = obs();
    @(posedge de_clk);
    cyc++;
    last_acc = acc;
    if (flush) sbq.delete();
    else if (acc) sbq.push_back('{e, cyc - 1});
    #1;
  endtask

  task automatic setin(input int u, input int v, input int mx, input int my,
                       input int mskx, input int msky, input int bp);
    ul_u = 11'(u); ul_v = 11'(v); mode_x = 2'(mx); mode_y = 2'(my);
    bitmask_x = 9'(mskx); bitmask_y = 9'(msky); bpt = 3'(bp);
    tfmt = 5'($urandom); pal_mode = 1'($urandom); clip = 1'($urandom);
    mipmap = 4'($urandom); exact = 1'($urandom);
  endtask

  task automatic setrand();
    int mx = (1 << $urandom_range(0, 9)) - 1;
    int my = (1 << $urandom_range(0, 9)) - 1;
    int u = int'($urandom_range(0, 2047));
    int v = int'($urandom_range(0, 2047));
    case ($urandom_range(0, 3))
      0: begin u = mx + int'($urandom_range(0, 2)) - 1; v = -int'($urandom_range(0, 2)); end
      1: begin u = 1023; v = my * 2 + 1; end
      default: ;
    endcase
    setin(u, v, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), mx, my,
          int'($urandom_range(0, 7)));
  endtask

  // Push one item and advance until it is visible at the output.
  task automatic run1();
    in_vld = 1'b1; tick(); in_vld = 1'b0;
    chk_i("lat1_vld", int'(out_vld), 0);
    tick();
    chk_i("lat2_vld", int'(out_vld), 1);
  endtask

  initial begin
    int pushed, pops0;
    de_rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    setin(0, 0, 0, 0, 0, 0, 0);
    tfmt = '0; pal_mode = 1'b0; clip = 1'b0; mipmap = '0; exact = 1'b0;
    #12;
    chk_i("rst_in_rdy", int'(in_rdy), 1);
    chk_i("rst_out_vld", int'(out_vld), 0);
    chk("rst_data", obs(), 128'h0);
    @(posedge de_clk); #1 de_rst = 1'b0;

    // repeat
    setin('h0FF, 'h010, 0, 0, 'hFF, 'hFF, 3);
    run1();
    chk_i("rep_ul_x", int'(ul_x), 'hFF);
    chk_i("rep_ur_x", int'(ur_x), 'h00);
    chk_i("rep_ll_y", int'(ll_y), 'h11);
    chk_i("rep_border", int'({border_ul, border_ur, border_ll, border_lr}), 0);
    tick();

    // clamp, including saturated +1 on v
    setin('h7FF, 'h3FF, 1, 1, 'h7F, 'h7F, 5);
    run1();
    chk_i("clamp_ul_x", int'(ul_x), 0);
    chk_i("clamp_ur_x", int'(ur_x), 0);
    chk_i("clamp_ul_y", int'(ul_y), 'h7F);
    chk_i("clamp_ll_y", int'(ll_y), 'h7F);
    tick();

    // mirror
    setin('h01F, 'h7FF, 2, 2, 'hF, 'hF, 5);
    run1();
    chk_i("mir_ul_x", int'(ul_x), 0);
    chk_i("mir_ur_x", int'(ur_x), 0);
    chk_i("mir_ul_y", int'(ul_y), 0);
    chk_i("mir_ll_y", int'(ll_y), 0);
    tick();

    // border
    setin('h03F, 'h000, 3, 3, 'h3F, 'h3F, 5);
    run1();
    chk_i("brd_flags", int'({border_ul, border_ur, border_ll, border_lr}), 'b0101);
    chk_i("brd_ur_x", int'(ur_x), 0);
    tick();

    // bank sort with both parities odd (UL tag 0, LR tag 8)
    setin(2, 1, 0, 0, 'h1FF, 'h1FF, 5);
    run1();
    chk_i("bank_ee", int'(ee_tag), 8);
    chk_i("bank_oo", int'(oo_tag), 0);
    tick();
    setin(1, 1, 0, 0, 'h1FF, 'h1FF, 5);
    run1();
    chk_i("same_word0", int'(same_word), 0);
    tick();
    setin(0, 1, 0, 0, 'h1FF, 'h1FF, 3);
    run1();
    chk_i("same_word1", int'(same_word), 1);
    tick();

    // back-to-back pushes with a 3-cycle downstream stall
    pushed = 0; pops0 = n_pop;
    for (int t = 0; t < 12; t++) begin
      out_rdy = !(t >= 2 && t < 5);
      if (pushed < 4) begin setrand(); in_vld = 1'b1; end
      else in_vld = 1'b0;
      tick();
      if (last_acc) pushed++;
    end
    chk_i("stall_pops", n_pop - pops0, 4);

    // flush beats a simultaneous push
    out_rdy = 1'b1;
    setrand(); in_vld = 1'b1; tick();
    setrand(); tick();
    setrand(); flush = 1'b1; #1;
    chk_i("flush_rdy", int'(in_rdy), 0);
    tick();
    flush = 1'b0; in_vld = 1'b0;
    chk_i("flush_vld", int'(out_vld), 0);
    repeat (3) tick();

    // reset while stalled
    setrand(); in_vld = 1'b1; tick(); setrand(); tick();
    in_vld = 1'b0; out_rdy = 1'b0; repeat (2) tick();
    #2 de_rst = 1'b1; #1;
    chk_i("rst_stall_vld", int'(out_vld), 0);
    chk("rst_stall_data", obs(), 128'h0);
    chk_i("rst_stall_rdy", int'(in_rdy), 1);
    sbq.delete(); stall_prev = 1'b0;
    @(posedge de_clk); #1 de_rst = 1'b0; out_rdy = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      setrand();
      in_vld  = $urandom_range(0, 3) != 0;
      out_rdy = $urandom_range(0, 3) != 0;
      flush   = $urandom_range(0, 49) == 0;
      tick();
    end
    flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    repeat (4) tick();
    chk_i("drain_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
